// File: rtl/calc1_chk_pkg.sv
// Shared command/response codes, expected-entry type and reference computation
// for the calc1 response checker.
package calc1_chk_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [1:0]  resp;
    logic [0:31] data;
  } exp_t;

  // Data is left at zero whenever the response is an error; the compare ignores it then.
  function automatic exp_t calc_expected(input logic [0:3] cmd, input logic [0:31] op1,
                                         input logic [0:31] op2);
    exp_t        e;
    logic [32:0] sum;
    sum    = {1'b0, op1} + {1'b0, op2};
    e.resp = RESP_ERR;
    e.data = 32'd0;
    case (cmd)
      CMD_ADD: begin
        e.resp = sum[32] ? RESP_ERR : RESP_OK;
        e.data = sum[32] ? 32'd0 : sum[31:0];
      end
      CMD_SUB: begin
        e.resp = (op2 > op1) ? RESP_ERR : RESP_OK;
        e.data = (op2 > op1) ? 32'd0 : op1 - op2;
      end
      CMD_LSH: begin
        e.resp = RESP_OK;
        e.data = op1 << op2[27:31];
      end
      CMD_RSH: begin
        e.resp = RESP_OK;
        e.data = op1 >> op2[27:31];
      end
      default: begin
        e.resp = RESP_ERR;
        e.data = 32'd0;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/calc1_chk_port.sv
// One calc1 port: request capture, expected-result queue, response compare and,
// with CALC1_CHECKER_TIMEOUT_EN defined, a head-entry age timer.
module calc1_chk_port
  import calc1_chk_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_data,
  input  logic [1:0]  out_resp,
  input  logic [0:31] out_data,
  output logic        pass_s,
  output logic        err_s,
  output logic        busy_s
);

  localparam int PW = $clog2(DEPTH);

  cap_state_e    state_r;
  logic [0:3]    cmd_r;
  logic [0:31]   op1_r;
  exp_t          q_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  exp_t head_s;
  exp_t new_s;
  logic push_s, pop_req_s, empty_s, full_s, pop_s, deq_s, accept_s, match_s, timeout_s;

`ifdef CALC1_CHECKER_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [AW-1:0] age_r;
`endif

  // Queue control and compare outcome for the current cycle.
  always_comb begin
    head_s    = q_r[rd_ptr_r];
    new_s     = calc_expected(cmd_r, op1_r, req_data);
    push_s    = (state_r == CAP_OP2);
    pop_req_s = (out_resp != RESP_NONE);
    empty_s   = (count_r == (PW + 1)'(0));
    full_s    = (count_r == (PW + 1)'(DEPTH));
    pop_s     = pop_req_s && !empty_s;
    match_s   = (head_s.resp == out_resp) && ((head_s.resp != RESP_OK) || (head_s.data == out_data));
`ifdef CALC1_CHECKER_TIMEOUT_EN
    timeout_s = !empty_s && !pop_req_s && (age_r == AW'(TIMEOUT));
`else
    timeout_s = 1'b0;
`endif
    deq_s     = pop_s || timeout_s;
    accept_s  = push_s && (!full_s || deq_s);
    pass_s    = pop_s && match_s;
    err_s     = (pop_req_s && empty_s) || (pop_s && !match_s) || (push_s && !accept_s) || timeout_s;
    busy_s    = !empty_s || push_s;
  end

  // Capture FSM: first non-NOP beat carries cmd/op1, the following beat op2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CAP_IDLE;
      cmd_r   <= CMD_NOP;
      op1_r   <= 32'd0;
    end else begin
      case (state_r)
        CAP_IDLE: begin
          if (req_cmd != CMD_NOP) begin
            state_r <= CAP_OP2;
            cmd_r   <= req_cmd;
            op1_r   <= req_data;
          end
        end
        CAP_OP2:  state_r <= CAP_IDLE;
        default:  state_r <= CAP_IDLE;
      endcase
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (accept_s) q_r[wr_ptr_r] <= new_s;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW + 1)'(0);
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (deq_s)    rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({accept_s, deq_s})
        2'b10:   count_r <= count_r + (PW + 1)'(1);
        2'b01:   count_r <= count_r - (PW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef CALC1_CHECKER_TIMEOUT_EN
  // Age of the current head; restarts whenever a new entry becomes head.
  always_ff @(posedge clk) begin
    if (reset || deq_s || empty_s) age_r <= AW'(0);
    else                           age_r <= age_r + AW'(1);
  end
`endif

endmodule

// File: rtl/calc1_checker.sv
// calc1 four-port response checker: per-port capture/compare plus merged
// saturating counters. Optional head timeout: CALC1_CHECKER_TIMEOUT_EN.
module calc1_checker
  import calc1_chk_pkg::*;
#(
  parameter int PORTS   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [0:3]       req_cmd_in  [1:PORTS],
  input  logic [0:31]      req_data_in [1:PORTS],
  input  logic [1:0]       out_resp_in [1:PORTS],
  input  logic [0:31]      out_data_in [1:PORTS],
  output logic [1:PORTS]   mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic             busy
);

  localparam int             SW      = CNT_W + $clog2(PORTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:PORTS] pass_s;
  logic [1:PORTS] err_s;
  logic [1:PORTS] busy_s;

  for (genvar p = 1; p <= PORTS; p++) begin : g_port
    calc1_chk_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_port (
      .clk      (c_clk),
      .reset    (reset),
      .req_cmd  (req_cmd_in[p]),
      .req_data (req_data_in[p]),
      .out_resp (out_resp_in[p]),
      .out_data (out_data_in[p]),
      .pass_s   (pass_s[p]),
      .err_s    (err_s[p]),
      .busy_s   (busy_s[p])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:PORTS] hits);
    logic [SW-1:0] sum;
    sum = SW'(base);
    for (int p = 1; p <= PORTS; p++) sum = sum + SW'(hits[p]);
    return (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Registered merge of per-port outcomes.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      mismatch   <= {PORTS{1'b0}};
      pass_count <= {CNT_W{1'b0}};
      err_count  <= {CNT_W{1'b0}};
      err_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mismatch   <= err_s;
      pass_count <= sat_add(pass_count, pass_s);
      err_count  <= sat_add(err_count, err_s);
      err_flag   <= err_flag | (|err_s);
      busy       <= |busy_s;
    end
  end

endmodule

// File: tb/tb_calc1_checker.sv
// Bench for calc1_checker: directed scenarios plus random traffic, scored
// against a queue-based reference model of the four calc1 ports.
module tb_calc1_checker;

  localparam int PORTS = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [0:3]     cmd   [1:PORTS];
  logic [0:31]    data  [1:PORTS];
  logic [1:0]     oresp [1:PORTS];
  logic [0:31]    odata [1:PORTS];
  logic [1:PORTS] mismatch;
  logic [CW-1:0]  pass_count, err_count;
  logic           err_flag, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  calc1_checker #(.PORTS(PORTS), .DEPTH(DEPTH), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .c_clk(clk), .reset(reset),
    .req_cmd_in(cmd), .req_data_in(data), .out_resp_in(oresp), .out_data_in(odata),
    .mismatch(mismatch), .pass_count(pass_count), .err_count(err_count),
    .err_flag(err_flag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int resp; bit [31:0] data; } ent_t;
  typedef struct { int due; bit [1:PORTS] mm; int pass; int err; bit flag; } obs_t;

  ent_t      mq [1:PORTS][$];
  bit        have_op1 [1:PORTS];
  int        m_cmd    [1:PORTS];
  bit [31:0] m_op1    [1:PORTS];
  int        age      [1:PORTS];
  int        m_pass, m_err;
  bit        m_flag;
  obs_t      expq [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic ent_t ref_exp(input int c, input bit [31:0] a, input bit [31:0] b);
    ent_t r;
    longint unsigned s;
    r.resp = 2;
    r.data = 32'd0;
    case (c)
      1: begin
        s = longint'(a) + longint'(b);
        if (s <= 64'hFFFF_FFFF) begin r.resp = 1; r.data = a + b; end
      end
      2: if (b <= a) begin r.resp = 1; r.data = a - b; end
      5: begin r.resp = 1; r.data = a << (b % 32); end
      6: begin r.resp = 1; r.data = a >> (b % 32); end
      default: r.resp = 2;
    endcase
    return r;
  endfunction

  function automatic bit [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [0:3] pick_cmd();
    case ($urandom_range(0, 9))
      0, 1: return 4'd1;
      2, 3: return 4'd2;
      4, 5: return 4'd5;
      6, 7: return 4'd6;
      8:    return 4'd3;
      default: return 4'($urandom_range(7, 15));
    endcase
  endfunction

  task automatic model_clear();
    for (int p = 1; p <= PORTS; p++) begin
      mq[p].delete();
      have_op1[p] = 1'b0;
      age[p] = 0;
    end
    m_pass = 0;
    m_err  = 0;
    m_flag = 1'b0;
  endtask

  task automatic idle();
    for (int p = 1; p <= PORTS; p++) begin
      cmd[p] = 4'd0; data[p] = 32'd0; oresp[p] = 2'd0; odata[p] = 32'd0;
    end
  endtask

  // Advance the model over the inputs currently driven, queue what the DUT
  // must show after the coming edge, then let that edge happen.
  task automatic step();
    bit [1:PORTS] mm;
    int np, ne;
    np = 0;
    ne = 0;
    mm = '0;
    for (int p = 1; p <= PORTS; p++) begin
      bit   e, ok, popped;
      int   sz0;
      ent_t h;
      e = 0; ok = 0; popped = 0;
      sz0 = mq[p].size();
      if (oresp[p] != 2'd0) begin
        if (sz0 == 0) e = 1;
        else begin
          h = mq[p].pop_front();
          popped = 1;
          if (h.resp == int'(oresp[p]) && (h.resp != 1 || h.data == odata[p])) ok = 1;
          else e = 1;
        end
      end
`ifdef CALC1_CHECKER_TIMEOUT_EN
      else if (sz0 != 0 && age[p] == TO) begin
        void'(mq[p].pop_front());
        popped = 1;
        e = 1;
      end
`endif
      if (have_op1[p]) begin
        have_op1[p] = 1'b0;
        if (mq[p].size() < DEPTH) mq[p].push_back(ref_exp(m_cmd[p], m_op1[p], data[p]));
        else e = 1;
      end else if (cmd[p] != 4'd0) begin
        have_op1[p] = 1'b1;
        m_cmd[p] = int'(cmd[p]);
        m_op1[p] = data[p];
      end
      age[p] = (popped || sz0 == 0) ? 0 : age[p] + 1;
      mm[p] = e;
      ne += int'(e);
      np += int'(ok);
    end
    m_pass = (m_pass + np > CMAX) ? CMAX : m_pass + np;
    m_err  = (m_err + ne > CMAX) ? CMAX : m_err + ne;
    m_flag = m_flag | (ne != 0);
    expq.push_back('{cyc + 1, mm, m_pass, m_err, m_flag});
    @(posedge clk);
    #1;
  endtask

  task automatic resp_head(input int p);
    if (mq[p].size() > 0) begin
      oresp[p] = 2'(mq[p][0].resp);
      odata[p] = mq[p][0].data;
    end else begin
      oresp[p] = 2'd0;
      odata[p] = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    chk("rst_pass", longint'(pass_count), 0);
    chk("rst_err", longint'(err_count), 0);
    chk("rst_flag", longint'(err_flag), 0);
    chk("rst_mismatch", longint'(mismatch), 0);
  endtask

  // Monitor: compare DUT outputs against each due expectation.
  always @(negedge clk) begin
    obs_t o;
    while (expq.size() > 0 && expq[0].due == cyc) begin
      o = expq.pop_front();
      chk("mismatch", longint'(mismatch), longint'(o.mm));
      chk("pass_count", longint'(pass_count), o.pass);
      chk("err_count", longint'(err_count), o.err);
      chk("err_flag", longint'(err_flag), longint'(o.flag));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    model_clear();
    do_reset();
    chk("rst_busy", longint'(busy), 0);

    // Port 1 ADD with a matching response.
    cmd[1] = 4'd1; data[1] = 32'hFFFF_0000; step();
    cmd[1] = 4'd0; data[1] = 32'h0000_FFFF; step();
    idle(); oresp[1] = 2'd1; odata[1] = 32'hFFFF_FFFF; step();
    idle(); step();
    chk("tp1_pass", longint'(pass_count), 1);
    chk("tp1_err", longint'(err_count), 0);

    // Port 2 ADD overflow: wrong resp then right resp.
    for (int k = 0; k < 2; k++) begin
      cmd[2] = 4'd1; data[2] = 32'hFFFF_FFFF; step();
      cmd[2] = 4'd0; data[2] = 32'h0000_0001; step();
      idle(); oresp[2] = (k == 0) ? 2'd1 : 2'd2; odata[2] = 32'h0; step();
      idle(); step();
    end
    chk("tp2_err", longint'(err_count), 1);
    chk("tp2_flag", longint'(err_flag), 1);
    chk("tp2_pass", longint'(pass_count), 2);

    // Port 3 SUB underflow and LSH by 31.
    cmd[3] = 4'd2; data[3] = 32'h0000_0001; step();
    cmd[3] = 4'd0; data[3] = 32'h8000_0000; step();
    idle(); oresp[3] = 2'd2; odata[3] = 32'h1234_5678; step();
    idle(); cmd[3] = 4'd5; data[3] = 32'h0000_0001; step();
    cmd[3] = 4'd0; data[3] = 32'h0000_001F; step();
    idle(); oresp[3] = 2'd1; odata[3] = 32'h8000_0000; step();
    idle(); step();
    chk("tp3_pass", longint'(pass_count), 4);

    // All ports at once, answered out of port order.
    for (int p = 1; p <= PORTS; p++) begin cmd[p] = 4'd1; data[p] = $urandom >> 1; end
    step();
    for (int p = 1; p <= PORTS; p++) begin cmd[p] = 4'd0; data[p] = $urandom >> 1; end
    step();
    idle();
    foreach (expq[i]) ;
    begin
      int order [4] = '{4, 2, 3, 1};
      for (int i = 0; i < 4; i++) begin
        idle(); resp_head(order[i]); step();
      end
    end
    idle(); repeat (3) step();
    chk("tp4_pass", longint'(pass_count), 8);
    chk("tp4_busy", longint'(busy), 0);

    // Port 4: unexpected response, then overflow at five requests.
    oresp[4] = 2'd1; odata[4] = 32'd0; step();
    idle(); step();
    chk("tp5_unexp", longint'(err_count), 2);
    for (int k = 0; k < 5; k++) begin
      cmd[4] = 4'd6; data[4] = 32'hF000_0000 + k; step();
      cmd[4] = 4'd0; data[4] = k; step();
    end
    idle(); repeat (2) step();
    chk("tp5_ovf", longint'(err_count), 3);
    chk("tp5_busy", longint'(busy), 1);
    for (int k = 0; k < 4; k++) begin idle(); resp_head(4); step(); end
    idle(); repeat (3) step();
    chk("tp5_pass", longint'(pass_count), 12);
    chk("tp5_idle", longint'(busy), 0);

    // Response in the push cycle of an empty queue: unexpected, entry kept.
    cmd[1] = 4'd2; data[1] = 32'd10; step();
    cmd[1] = 4'd0; data[1] = 32'd3; oresp[1] = 2'd1; odata[1] = 32'd7; step();
    idle(); resp_head(1); step();
    idle(); step();
    chk("tp6_err", longint'(err_count), 4);
    chk("tp6_pass", longint'(pass_count), 13);

`ifdef CALC1_CHECKER_TIMEOUT_EN
    cmd[1] = 4'd1; data[1] = 32'd1; step();
    cmd[1] = 4'd0; data[1] = 32'd2; step();
    idle(); repeat (TO + 4) step();
    chk("to_err", longint'(err_count), 5);
`endif

    // Reset during the op2 beat discards the capture.
    cmd[2] = 4'd1; data[2] = 32'd5; step();
    cmd[2] = 4'd0; data[2] = 32'd6;
    do_reset();
    idle(); repeat (3) step();
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_err", longint'(err_count), 0);

    // Random traffic with occasional corruption, unexpected responses and overflows.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 1; p <= PORTS; p++) begin
        if (have_op1[p]) begin
          cmd[p] = 4'($urandom); data[p] = rnd_val();
        end else if ($urandom_range(0, 99) < 45) begin
          cmd[p] = pick_cmd(); data[p] = rnd_val();
        end else begin
          cmd[p] = 4'd0; data[p] = $urandom;
        end
        if (mq[p].size() > 0 && $urandom_range(0, 99) < 50) begin
          resp_head(p);
          if (oresp[p] != 2'd1) odata[p] = $urandom;
          if ($urandom_range(0, 99) < 10) begin
            if ($urandom_range(0, 1) == 0) oresp[p] = (oresp[p] == 2'd1) ? 2'd2 : 2'd1;
            else odata[p] = odata[p] ^ (32'h1 << $urandom_range(0, 31));
          end
        end else if ($urandom_range(0, 99) < 2) begin
          oresp[p] = 2'($urandom_range(1, 3)); odata[p] = $urandom;
        end else begin
          oresp[p] = 2'd0; odata[p] = 32'd0;
        end
      end
      step();
    end

    // Drain all queues and confirm the checker goes idle.
    idle(); step();
    for (int i = 0; i < 40; i++) begin
      for (int p = 1; p <= PORTS; p++) resp_head(p);
      step();
      idle();
    end
    repeat (3) step();
    chk("final_busy", longint'(busy), 0);
    chk("final_flag", longint'(err_flag), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
